// File: rtl/ysyx_22040750_mem_arbiter_pkg.sv
// Shared encodings for the IF/MEM memory-port arbiter.
package ysyx_22040750_mem_arbiter_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_RESP = 2'd2
   } arb_state_e;

   typedef enum logic {
      OWN_IF  = 1'b0,
      OWN_MEM = 1'b1
   } arb_owner_e;

   // Instruction fetch always reads a full 64-bit word with no sign extension.
   localparam logic [8:0] IF_RSTRB = 9'h0FF;

endpackage

// File: rtl/ysyx_22040750_arb_timeout.sv
// Saturating transaction watchdog: cleared on load, counts while enabled,
// and flags expiry once the count reaches TIMEOUT.
module ysyx_22040750_arb_timeout #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic I_sys_clk,
   input  logic I_rst_n,
   input  logic I_load,
   input  logic I_en,
   output logic O_expired
);

   localparam int unsigned CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

   logic [CW-1:0] cnt;

   always_ff @(posedge I_sys_clk or negedge I_rst_n) begin
      if (!I_rst_n) begin
         cnt <= '0;
      end else if (I_load) begin
         cnt <= '0;
      end else if (I_en && (cnt != LIMIT)) begin
         cnt <= cnt + 1'b1;
      end
   end

   assign O_expired = (cnt == LIMIT);

endmodule

// File: rtl/ysyx_22040750_mem_arbiter.sv
// Two-master (IF read-only, MEM read/write) arbiter onto a single memory port,
// one transaction outstanding, MEM has fixed priority, timeout recovery.
module ysyx_22040750_mem_arbiter
   import ysyx_22040750_mem_arbiter_pkg::*;
#(
   parameter int unsigned AW      = 32,
   parameter int unsigned DW      = 64,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic              I_sys_clk,
   input  logic              I_rst_n,
   input  logic              I_if_rd_en,
   input  logic [AW-1:0]     I_if_addr,
   output logic              O_if_ready,
   output logic              O_if_rvalid,
   output logic [DW-1:0]     O_if_rdata,
   input  logic              I_mem_rd_en,
   input  logic              I_mem_wr_en,
   input  logic [AW-1:0]     I_mem_addr,
   input  logic [DW-1:0]     I_mem_wdata,
   input  logic [DW/8-1:0]   I_mem_wstrb,
   input  logic [DW/8:0]     I_mem_rstrb,
   output logic              O_mem_ready,
   output logic              O_mem_rvalid,
   output logic              O_mem_bvalid,
   output logic [DW-1:0]     O_mem_rdata,
   output logic              O_bus_rd_en,
   output logic              O_bus_wr_en,
   output logic [AW-1:0]     O_bus_addr,
   output logic [DW-1:0]     O_bus_wdata,
   output logic [DW/8-1:0]   O_bus_wstrb,
   output logic [DW/8:0]     O_bus_rstrb,
   input  logic              I_bus_ready,
   input  logic              I_bus_rvalid,
   input  logic              I_bus_bvalid,
   input  logic [DW-1:0]     I_bus_rdata,
   output logic              O_err
);

   localparam int unsigned RW = DW/8 + 1;

   arb_state_e      state;
   arb_owner_e      owner_q;
   logic            is_wr_q;
   logic            bus_rd_q;
   logic            bus_wr_q;
   logic [AW-1:0]   addr_q;
   logic [DW-1:0]   wdata_q;
   logic [DW/8-1:0] wstrb_q;
   logic [RW-1:0]   rstrb_q;
   logic            err_q;

   logic idle, busy, mem_req, grant_mem, grant_if;
   logic expired, rsp_match, rsp_window, rsp_fire, to_fire, done;
   logic pulse_rd, pulse_wr, spurious, err_set;

   assign idle    = (state == S_IDLE);
   assign busy    = !idle;
   assign mem_req = I_mem_rd_en | I_mem_wr_en;

   // Grants are combinational and suppressed while reset is held.
   assign grant_mem = I_rst_n & idle & mem_req;
   assign grant_if  = I_rst_n & idle & ~mem_req & I_if_rd_en;

   ysyx_22040750_arb_timeout #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout (
      .I_sys_clk (I_sys_clk),
      .I_rst_n   (I_rst_n),
      .I_load    (grant_mem | grant_if),
      .I_en      (busy),
      .O_expired (expired)
   );

   // A genuine response in RESP beats a timeout in the same cycle; in REQ the timeout wins.
   assign rsp_match  = is_wr_q ? I_bus_bvalid : I_bus_rvalid;
   assign rsp_window = (state == S_RESP) | ((state == S_REQ) & I_bus_ready);
   assign to_fire    = busy & expired & ~((state == S_RESP) & rsp_match);
   assign rsp_fire   = rsp_window & rsp_match & ~to_fire;
   assign done       = rsp_fire | to_fire;
   assign pulse_rd   = done & ~is_wr_q;
   assign pulse_wr   = done & is_wr_q;

   assign spurious = (I_bus_rvalid & ~(rsp_fire & ~is_wr_q)) |
                     (I_bus_bvalid & ~(rsp_fire & is_wr_q));
   assign err_set  = spurious | to_fire | (grant_mem & I_mem_rd_en & I_mem_wr_en);

   assign O_if_ready   = grant_if;
   assign O_mem_ready  = grant_mem;
   assign O_if_rvalid  = pulse_rd & (owner_q == OWN_IF);
   assign O_mem_rvalid = pulse_rd & (owner_q == OWN_MEM);
   assign O_mem_bvalid = pulse_wr & (owner_q == OWN_MEM);
   assign O_if_rdata   = (O_if_rvalid & rsp_fire) ? I_bus_rdata : '0;
   assign O_mem_rdata  = (O_mem_rvalid & rsp_fire) ? I_bus_rdata : '0;

   assign O_bus_rd_en = bus_rd_q & ~expired;
   assign O_bus_wr_en = bus_wr_q & ~expired;
   assign O_bus_addr  = addr_q;
   assign O_bus_wdata = wdata_q;
   assign O_bus_wstrb = wstrb_q;
   assign O_bus_rstrb = rstrb_q;
   assign O_err       = err_q;

   always_ff @(posedge I_sys_clk or negedge I_rst_n) begin
      if (!I_rst_n) begin
         state    <= S_IDLE;
         owner_q  <= OWN_IF;
         is_wr_q  <= 1'b0;
         bus_rd_q <= 1'b0;
         bus_wr_q <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         wstrb_q  <= '0;
         rstrb_q  <= '0;
         err_q    <= 1'b0;
      end else begin
         err_q <= err_q | err_set;
         case (state)
            S_IDLE: begin
               if (grant_mem) begin
                  owner_q  <= OWN_MEM;
                  is_wr_q  <= I_mem_wr_en;
                  bus_wr_q <= I_mem_wr_en;
                  bus_rd_q <= ~I_mem_wr_en;
                  addr_q   <= I_mem_addr;
                  wdata_q  <= I_mem_wdata;
                  wstrb_q  <= I_mem_wstrb;
                  rstrb_q  <= I_mem_rstrb;
                  state    <= S_REQ;
               end else if (grant_if) begin
                  owner_q  <= OWN_IF;
                  is_wr_q  <= 1'b0;
                  bus_wr_q <= 1'b0;
                  bus_rd_q <= 1'b1;
                  addr_q   <= I_if_addr;
                  wdata_q  <= '0;
                  wstrb_q  <= '0;
                  rstrb_q  <= RW'(IF_RSTRB);
                  state    <= S_REQ;
               end
            end
            S_REQ: begin
               if (to_fire) begin
                  bus_rd_q <= 1'b0;
                  bus_wr_q <= 1'b0;
                  state    <= S_IDLE;
               end else if (I_bus_ready) begin
                  bus_rd_q <= 1'b0;
                  bus_wr_q <= 1'b0;
                  state    <= rsp_fire ? S_IDLE : S_RESP;
               end
            end
            S_RESP: begin
               if (done) begin
                  state <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ysyx_22040750_mem_arbiter.sv
// Directed scoreboard bench for the IF/MEM memory-port arbiter (TIMEOUT=4).
module tb_ysyx_22040750_mem_arbiter;

   localparam int unsigned AW = 32;
   localparam int unsigned DW = 64;

   localparam int K_IF_READY  = 0;
   localparam int K_MEM_READY = 1;
   localparam int K_IF_RV     = 2;
   localparam int K_MEM_RV    = 3;
   localparam int K_MEM_BV    = 4;

   typedef struct {
      int          kind;
      logic [63:0] data;
   } ev_t;

   logic            clk, rst_n;
   logic            if_rd_en;
   logic [AW-1:0]   if_addr;
   logic            if_ready, if_rvalid;
   logic [DW-1:0]   if_rdata;
   logic            mem_rd_en, mem_wr_en;
   logic [AW-1:0]   mem_addr;
   logic [DW-1:0]   mem_wdata;
   logic [DW/8-1:0] mem_wstrb;
   logic [DW/8:0]   mem_rstrb;
   logic            mem_ready, mem_rvalid, mem_bvalid;
   logic [DW-1:0]   mem_rdata;
   logic            bus_rd_en, bus_wr_en;
   logic [AW-1:0]   bus_addr;
   logic [DW-1:0]   bus_wdata;
   logic [DW/8-1:0] bus_wstrb;
   logic [DW/8:0]   bus_rstrb;
   logic            bus_ready, bus_rvalid, bus_bvalid;
   logic [DW-1:0]   bus_rdata;
   logic            err;

   int  errors = 0;
   int  checks = 0;
   ev_t sbq[$];

   ysyx_22040750_mem_arbiter #(
      .AW      (AW),
      .DW      (DW),
      .TIMEOUT (4)
   ) dut (
      .I_sys_clk    (clk),
      .I_rst_n      (rst_n),
      .I_if_rd_en   (if_rd_en),
      .I_if_addr    (if_addr),
      .O_if_ready   (if_ready),
      .O_if_rvalid  (if_rvalid),
      .O_if_rdata   (if_rdata),
      .I_mem_rd_en  (mem_rd_en),
      .I_mem_wr_en  (mem_wr_en),
      .I_mem_addr   (mem_addr),
      .I_mem_wdata  (mem_wdata),
      .I_mem_wstrb  (mem_wstrb),
      .I_mem_rstrb  (mem_rstrb),
      .O_mem_ready  (mem_ready),
      .O_mem_rvalid (mem_rvalid),
      .O_mem_bvalid (mem_bvalid),
      .O_mem_rdata  (mem_rdata),
      .O_bus_rd_en  (bus_rd_en),
      .O_bus_wr_en  (bus_wr_en),
      .O_bus_addr   (bus_addr),
      .O_bus_wdata  (bus_wdata),
      .O_bus_wstrb  (bus_wstrb),
      .O_bus_rstrb  (bus_rstrb),
      .I_bus_ready  (bus_ready),
      .I_bus_rvalid (bus_rvalid),
      .I_bus_bvalid (bus_bvalid),
      .I_bus_rdata  (bus_rdata),
      .O_err        (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic string kname(int k);
      case (k)
         K_IF_READY:  return "if_ready";
         K_MEM_READY: return "mem_ready";
         K_IF_RV:     return "if_rvalid";
         K_MEM_RV:    return "mem_rvalid";
         default:     return "mem_bvalid";
      endcase
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic expect_ev(input int kind, input logic [63:0] data);
      ev_t e;
      e.kind = kind;
      e.data = data;
      sbq.push_back(e);
   endtask

   task automatic mon_step(input int kind, input logic v, input logic [63:0] d);
      ev_t e;
      if (v) begin
         checks++;
         if (sbq.size() == 0) begin
            errors++;
            $display("FAIL unexpected_%s actual=1 required=0 at %0t", kname(kind), $time);
         end else begin
            e = sbq.pop_front();
            if (e.kind != kind || e.data !== d) begin
               errors++;
               $display("FAIL event actual=%s/%h required=%s/%h at %0t",
                        kname(kind), d, kname(e.kind), e.data, $time);
            end
         end
      end
   endtask

   always @(negedge clk) begin
      mon_step(K_IF_READY,  if_ready,   64'h0);
      mon_step(K_MEM_READY, mem_ready,  64'h0);
      mon_step(K_IF_RV,     if_rvalid,  if_rdata);
      mon_step(K_MEM_RV,    mem_rvalid, mem_rdata);
      mon_step(K_MEM_BV,    mem_bvalid, 64'h0);
      if (!if_rvalid)  chk("if_rdata_quiet",  if_rdata,  64'h0);
      if (!mem_rvalid) chk("mem_rdata_quiet", mem_rdata, 64'h0);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0;
      if_rd_en = 1'b0;  if_addr = '0;
      mem_rd_en = 1'b0; mem_wr_en = 1'b0; mem_addr = '0;
      mem_wdata = '0;   mem_wstrb = '0;   mem_rstrb = '0;
      bus_ready = 1'b0; bus_rvalid = 1'b0; bus_bvalid = 1'b0; bus_rdata = '0;
      tick(); tick();
      chk("rst_bus_rd_en", 64'(bus_rd_en), 64'h0);
      chk("rst_bus_wr_en", 64'(bus_wr_en), 64'h0);
      chk("rst_bus_addr",  64'(bus_addr),  64'h0);
      chk("rst_err",       64'(err),       64'h0);
      rst_n = 1'b1;
      tick();

      // IF read alone
      if_rd_en = 1'b1; if_addr = 32'h8000_0000;
      expect_ev(K_IF_READY, 64'h0);
      tick();
      if_rd_en = 1'b0;
      chk("t1_bus_rd_en", 64'(bus_rd_en), 64'h1);
      chk("t1_bus_wr_en", 64'(bus_wr_en), 64'h0);
      chk("t1_bus_addr",  64'(bus_addr),  64'h8000_0000);
      chk("t1_bus_rstrb", 64'(bus_rstrb), 64'h0FF);
      bus_ready = 1'b1;
      tick();
      bus_ready = 1'b0;
      bus_rvalid = 1'b1; bus_rdata = 64'h1122_3344_5566_7788;
      expect_ev(K_IF_RV, 64'h1122_3344_5566_7788);
      tick();
      bus_rvalid = 1'b0; bus_rdata = '0;

      // Simultaneous IF read and MEM write: MEM first
      if_rd_en = 1'b1; if_addr = 32'h8000_2000;
      mem_wr_en = 1'b1; mem_addr = 32'h8000_1000; mem_wdata = 64'hDEAD; mem_wstrb = 8'h03;
      expect_ev(K_MEM_READY, 64'h0);
      tick();
      mem_wr_en = 1'b0;
      chk("t2_bus_wr_en", 64'(bus_wr_en), 64'h1);
      chk("t2_bus_rd_en", 64'(bus_rd_en), 64'h0);
      chk("t2_bus_addr",  64'(bus_addr),  64'h8000_1000);
      chk("t2_bus_wdata", bus_wdata,      64'hDEAD);
      chk("t2_bus_wstrb", 64'(bus_wstrb), 64'h03);
      bus_ready = 1'b1;
      tick();
      bus_ready = 1'b0; bus_bvalid = 1'b1;
      expect_ev(K_MEM_BV, 64'h0);
      tick();
      bus_bvalid = 1'b0;
      expect_ev(K_IF_READY, 64'h0);
      tick();
      if_rd_en = 1'b0;
      chk("t2_if_bus_rd_en", 64'(bus_rd_en), 64'h1);
      chk("t2_if_bus_addr",  64'(bus_addr),  64'h8000_2000);
      bus_ready = 1'b1; bus_rvalid = 1'b1; bus_rdata = 64'h0BAD_F00D_0000_0001;
      expect_ev(K_IF_RV, 64'h0BAD_F00D_0000_0001);
      tick();
      bus_ready = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;
      chk("t2_err", 64'(err), 64'h0);

      // Zero-latency MEM read, then immediate grant proves return to IDLE
      mem_rd_en = 1'b1; mem_addr = 32'h8000_0100; mem_rstrb = 9'h1FF;
      expect_ev(K_MEM_READY, 64'h0);
      tick();
      mem_rd_en = 1'b0;
      chk("t3_bus_rstrb", 64'(bus_rstrb), 64'h1FF);
      bus_ready = 1'b1; bus_rvalid = 1'b1; bus_rdata = 64'hCAFE_0000_F00D_0042;
      expect_ev(K_MEM_RV, 64'hCAFE_0000_F00D_0042);
      tick();
      bus_ready = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;
      if_rd_en = 1'b1; if_addr = 32'h8000_0040;
      expect_ev(K_IF_READY, 64'h0);
      tick();
      if_rd_en = 1'b0;

      // Slave never answers this IF read: timeout after 4 cycles
      chk("t4_bus_rd_en_c0", 64'(bus_rd_en), 64'h1);
      tick(); tick(); tick();
      chk("t4_bus_rd_en_c3", 64'(bus_rd_en), 64'h1);
      chk("t4_err_before",   64'(err),       64'h0);
      expect_ev(K_IF_RV, 64'h0);
      tick();
      chk("t4_bus_rd_dropped", 64'(bus_rd_en), 64'h0);
      tick();
      chk("t4_err_after", 64'(err), 64'h1);

      // Next request accepted; reset while it waits in RESP
      mem_rd_en = 1'b1; mem_addr = 32'h8000_0200; mem_rstrb = 9'h00F;
      expect_ev(K_MEM_READY, 64'h0);
      tick();
      mem_rd_en = 1'b0;
      chk("t5_bus_rd_en", 64'(bus_rd_en), 64'h1);
      bus_ready = 1'b1;
      tick();
      bus_ready = 1'b0;
      if_rd_en = 1'b1;
      rst_n = 1'b0;
      #1;
      chk("t5_rst_err",      64'(err),       64'h0);
      chk("t5_rst_bus_rd",   64'(bus_rd_en), 64'h0);
      chk("t5_rst_if_ready", 64'(if_ready),  64'h0);
      chk("t5_rst_bus_addr", 64'(bus_addr),  64'h0);
      tick(); tick();
      if_rd_en = 1'b0;
      rst_n = 1'b1;
      tick(); tick();
      chk("t5_post_err",    64'(err),       64'h0);
      chk("t5_post_bus_rd", 64'(bus_rd_en), 64'h0);

      // Spurious read data while IDLE
      bus_rvalid = 1'b1; bus_rdata = 64'h55;
      tick();
      bus_rvalid = 1'b0; bus_rdata = '0;
      chk("t6_spurious_err", 64'(err), 64'h1);

      // MEM read and write together: write wins and flags an error
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      chk("t7_err_clear", 64'(err), 64'h0);
      mem_rd_en = 1'b1; mem_wr_en = 1'b1; mem_addr = 32'h8000_0300;
      mem_wdata = 64'hBEEF; mem_wstrb = 8'hF0;
      expect_ev(K_MEM_READY, 64'h0);
      tick();
      mem_rd_en = 1'b0; mem_wr_en = 1'b0;
      chk("t7_bus_wr_en", 64'(bus_wr_en), 64'h1);
      chk("t7_bus_rd_en", 64'(bus_rd_en), 64'h0);
      chk("t7_bus_wdata", bus_wdata,      64'hBEEF);
      chk("t7_err",       64'(err),       64'h1);
      bus_ready = 1'b1; bus_bvalid = 1'b1;
      expect_ev(K_MEM_BV, 64'h0);
      tick();
      bus_ready = 1'b0; bus_bvalid = 1'b0;
      tick(); tick();

      chk("scoreboard_drained", 64'(sbq.size()), 64'h0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
